// File: rtl/result_collector_pkg.sv
// Shared types and constants for the complex result collector.
// The narrowing macro RESULT_SAT_EN is consumed by sat_narrow.
package result_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Both accumulator input and narrowed output keep 11 fraction bits.
  localparam int FRAC_BITS = 11;

  function automatic int depth_of(input int dim);
    return dim * dim;
  endfunction

  function automatic int idx_w_of(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

  // Largest and smallest values representable in a signed w-bit output.
  function automatic longint sat_hi(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational ACC_W -> OUT_W narrowing; binary point unchanged.
// RESULT_SAT_EN defined: clamp to the OUT_W signed range; undefined: truncate and wrap.
module sat_narrow
  import result_collector_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] nar_out
);

`ifdef RESULT_SAT_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(OUT_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(OUT_W));

  always_comb begin
    nar_out = acc_in[OUT_W-1:0];
    if ($signed(acc_in) > HI) begin
      nar_out = HI[OUT_W-1:0];
    end else if ($signed(acc_in) < LO) begin
      nar_out = LO[OUT_W-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc_in[ACC_W-1:OUT_W];
  assign nar_out   = acc_in[OUT_W-1:0];
`endif

endmodule

// File: rtl/result_collector.sv
// Captures one complex element per rising flag_r edge into a DIM*DIM buffer, then
// streams it row-major over valid/ready. Optional saturation via RESULT_SAT_EN.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DIM   = 3,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       flag_r,
  input  logic                       flag_i,
  input  logic [ACC_W-1:0]           acc_r,
  input  logic [ACC_W-1:0]           acc_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_real,
  output logic [OUT_W-1:0]           out_imag,
  output logic [idx_w_of(DIM)-1:0]   out_index,
  output logic                       out_last,
  output logic                       done,
  output logic                       err_overrun,
  output logic                       err_sync
);

  localparam int                DEPTH = depth_of(DIM);
  localparam int                IDX_W = idx_w_of(DIM);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic             flag_r_q;
  logic             capture;
  logic             store;

  logic [ACC_W-1:0] mem_r [DEPTH];
  logic [ACC_W-1:0] mem_i [DEPTH];
  logic [OUT_W-1:0] nar_r;
  logic [OUT_W-1:0] nar_i;

  assign capture = flag_r & ~flag_r_q;
  // A simultaneous start wins over the capture.
  assign store   = (state == ST_COLLECT) && capture && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      flag_r_q    <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      err_sync    <= 1'b0;
    end else begin
      flag_r_q <= flag_r;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_COLLECT;
            wr_cnt      <= '0;
            err_overrun <= 1'b0;
            err_sync    <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (start) begin
            wr_cnt      <= '0;
            err_overrun <= 1'b0;
            err_sync    <= 1'b0;
          end else if (capture) begin
            if (!flag_i) begin
              err_sync <= 1'b1;
            end
            if (wr_cnt == LAST) begin
              state     <= ST_DRAIN;
              wr_cnt    <= '0;
              rd_cnt    <= '0;
              out_valid <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (capture) begin
            err_overrun <= 1'b1;
          end
          if (out_ready) begin
            if (rd_cnt == LAST) begin
              state     <= ST_IDLE;
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Buffer has no reset; its contents only matter once all entries are rewritten.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_r[wr_cnt] <= acc_r;
      mem_i[wr_cnt] <= acc_i;
    end
  end

  sat_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_nar_r (
    .acc_in  (mem_r[rd_cnt]),
    .nar_out (nar_r)
  );

  sat_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_nar_i (
    .acc_in  (mem_i[rd_cnt]),
    .nar_out (nar_i)
  );

  // Data fields are forced to zero outside DRAIN so reset and idle values are defined.
  assign out_real  = out_valid ? nar_r : '0;
  assign out_imag  = out_valid ? nar_i : '0;
  assign out_index = out_valid ? rd_cnt : '0;
  assign out_last  = out_valid && (rd_cnt == LAST);

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the complex matrix-product datapath. Watches the real/imaginary accumulator outputs and their completion flags, captures one complex result element per completed dot product into a DIM×DIM buffer, then drains the full result matrix in row-major order over a valid/ready stream. It also narrows results from Q21.11 to a 16-bit output and reports sequencing errors.

## Interface
- `DIM`, 3, matrix dimension; buffer depth is DIM*DIM.
- `ACC_W`, 32, accumulator input width, signed Q21.11.
- `OUT_W`, 16, output width, signed Q5.11.
- `clk` input 1: single clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that arms a new collection.
- `flag_r` input 1: real accumulator completion flag.
- `flag_i` input 1: imaginary accumulator completion flag.
- `acc_r` input ACC_W: real accumulator value, signed.
- `acc_i` input ACC_W: imaginary accumulator value, signed.
- `out_valid` output 1: stream valid.
- `out_ready` input 1: stream ready.
- `out_real` output OUT_W: narrowed real part.
- `out_imag` output OUT_W: narrowed imaginary part.
- `out_index` output clog2(DIM*DIM): row-major element index.
- `out_last` output 1: high with element DIM*DIM-1.
- `done` output 1: one-cycle pulse after the last transfer.
- `err_overrun` output 1: sticky error.
- `err_sync` output 1: sticky error.

## Operation
- States and transitions:
  - IDLE → COLLECT on `start`.
  - COLLECT → DRAIN when the DIM*DIM-th element is stored.
  - DRAIN → IDLE after the last handshake.
- Capture event: rising edge of `flag_r`, i.e. `flag_r`=1 while its registered previous value was 0. Edge registers reset to 0.
- On a capture event in COLLECT:
  - `acc_r`/`acc_i` are written to buffer entry `wr_cnt`, and `wr_cnt` increments.
  - If `flag_i`=0 in the same cycle, `err_sync` is set. The data is still stored.
- Capture events in IDLE are ignored.
- Capture events in DRAIN are dropped and set `err_overrun`.
- `start` in COLLECT: restarts collection, clearing `wr_cnt`, `err_overrun` and `err_sync`. Buffer contents are not cleared.
- `start` in IDLE clears both errors. `start` in DRAIN is ignored.
- `start` and a capture event in the same cycle in COLLECT: the restart wins and the capture is discarded.
- DRAIN:
  - `out_valid`=1 continuously.
  - Outputs present buffer entry `rd_cnt`, with `out_index`=`rd_cnt`.
  - A transfer occurs on a cycle with `out_valid`&`out_ready`; `rd_cnt` increments on that cycle.
  - Output data is held stable while `out_ready`=0.
- Narrowing: OUT_W bits are taken as bits [OUT_W-1:0] of the accumulator (Q21.11 → Q5.11, binary point preserved). Overflow handling is set by the macro in Configuration.
- Reset: state IDLE, all counters 0, and every output 0 (`out_valid`, `out_real`, `out_imag`, `out_index`, `out_last`, `done`, `err_overrun`, `err_sync`). Buffer contents are don't-care. A reset mid-DRAIN aborts the stream immediately.

## Timing
- Capture latency: a flag edge sampled at edge N is stored at edge N.
- If that store is the final element, the state is DRAIN after edge N and `out_valid` is high in cycle N+1.
- Stream throughput: one element per cycle while `out_ready`=1. Minimum drain time is DIM*DIM cycles.
- `done` is high for exactly the one cycle after the edge that completes the last transfer. `out_valid`=0 in that same cycle.
- Flags are edge-detected, so a flag held high for several cycles produces exactly one capture.
- Back-to-back edges are legal: flag high, low, high on alternate cycles yields a capture every 2 cycles.

## Configuration
- `RESULT_SAT_EN` defined:
  - Values above 32767 (in Q5.11 LSBs) clamp to 0x7FFF.
  - Values below −32768 clamp to 0x8000.
  - Applied independently to the real and imaginary parts.
- `RESULT_SAT_EN` undefined: plain truncation, so upper bits are discarded and values wrap.

## Structure
- Package `result_collector_pkg`:
  - State enum (IDLE/COLLECT/DRAIN).
  - Depth and index-width functions of DIM.
  - Q-format fraction-bit constant (11).
  - OUT_W saturation limits.
- Sub-module `sat_narrow`: combinational ACC_W→OUT_W narrowing with the macro-selected behaviour. Instantiated twice, once for the real part and once for the imaginary part.
- The buffer is a register array; no RAM inference is required.

## Test plan
- Basic drain:
  - Stimulus: `start`, then 9 flag pulses with `acc_r`=k·2048 and `acc_i`=−k·2048 for k=0..8, with `out_ready`=1.
  - Required: 9 consecutive transfers, index 0..8, `out_real`=k·2048 (16-bit), `out_last` only at index 8, `done` one cycle later.
- Backpressure:
  - Stimulus: same load, `out_ready` toggled 1,0,0,1…
  - Required: no element skipped or duplicated; data held stable while `out_ready`=0.
- Overflow:
  - Stimulus: `acc_r`=40960 (20.0).
  - Required: with `RESULT_SAT_EN`, `out_real`=0x7FFF. Without it, `out_real`=0xA000. `acc_i`=−40960 gives 0x8000 and 0x6000 respectively.
- Errors:
  - Stimulus A: a flag edge during DRAIN. Required: `err_overrun`=1 and the stream is unchanged.
  - Stimulus B: `flag_r` edge with `flag_i`=0. Required: `err_sync`=1.
  - Stimulus C: a subsequent `start`. Required: both errors clear.
- Held flag / restart:
  - Stimulus: `flag_r`=`flag_i`=1 held for 5 cycles.
  - Required: one capture only.
  - Stimulus: `start` after 4 captures. Required: the next 9 captures drain as indices 0..8.
- Reset mid-DRAIN:
  - Stimulus: `rst` after 3 transfers.
  - Required: next cycle `out_valid`=0, `done`=0, errors=0, and the state waits for `start`.
